pe_depacketizer_fifo: RTL and testbench

// - Clocked, parametrised successor of the PE depacketizer. Sits between the NoC router port and one PE.
// - Accepts one packet per valid/ready transfer and decodes type and destination address.
// - Steers the payload into one of three FIFOs: pixel (ifmap), filter or partial-sum.
// - Drops misaddressed or reserved-type packets and counts them.

---
 rtl/pe_depacketizer_fifo.sv | 228 ++++++++++++++++++++++
 tb/tb_pe_depacketizer_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_depacketizer_fifo.sv
// pe_depacketizer_fifo: takes NoC packets from the router port and decodes each
// one. Packets addressed to this PE go, by type, into a pixel, filter or
// partial-sum FIFO. Misaddressed and reserved-type packets are dropped and
// counted.
// Optional feature macro: DEPKT_BROADCAST_EN. When it is defined, the all-ones
// destination address is accepted by every PE.
//
// Handshake rule for every port pair in this file: a transfer happens at the
// posedge where valid && ready are both high. A source holds its data stable
// while valid && !ready. Valid does not depend on ready.
//
// Debug: o_state shows the FSM state (0 = IDLE, 1 = DECODE, 2 = WAIT).

module pe_depkt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  output logic         o_full,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // Full and empty come from the registered count only. A pop in the same
  // cycle never frees a slot for that cycle's push.
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_valid = (r_count != '0);
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = o_valid && i_ready;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are meaningless while the count is zero, so it has no reset
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end
endmodule

module pe_depacketizer_fifo #(
  parameter  int DWIDTH     = 8,
  parameter  int NPIX       = 5,
  parameter  int NFILT      = 3,
  parameter  int PSUM_W     = 16,
  parameter  int ADDR_W     = 3,
  parameter  int FIFO_DEPTH = 4,
  parameter  int MY_ADDR    = 0,
  localparam int PWIDTH     = 2 + 2*ADDR_W + NPIX*DWIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [PWIDTH-1:0]       i_in_data,
  output logic                    o_pix_valid,
  input  logic                    i_pix_ready,
  output logic [NPIX*DWIDTH-1:0]  o_pix_data,
  output logic [ADDR_W-1:0]       o_pix_src,
  output logic                    o_filt_valid,
  input  logic                    i_filt_ready,
  output logic [NFILT*DWIDTH-1:0] o_filt_data,
  output logic                    o_psum_valid,
  input  logic                    i_psum_ready,
  output logic [PSUM_W-1:0]       o_psum_data,
  output logic [7:0]              o_drop_cnt,
  output logic [1:0]              o_state
);
  localparam int PLW = NPIX*DWIDTH;
  localparam logic [ADDR_W-1:0] LP_MY_ADDR = ADDR_W'(MY_ADDR);
  localparam logic [1:0] T_FILT  = 2'b00;
  localparam logic [1:0] T_IFMAP = 2'b01;
  localparam logic [1:0] T_PSUM  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic [PWIDTH-1:0] r_hold;
  logic [7:0]        r_drop_cnt;

  logic [1:0]        w_type;
  logic [ADDR_W-1:0] w_dst;
  logic [ADDR_W-1:0] w_src;
  logic [PLW-1:0]    w_payload;
  logic              w_addr_ok;
  logic              w_drop;
  logic              w_tgt_full;
  logic              w_active;
  logic              w_push;
  logic              w_pix_full;
  logic              w_filt_full;
  logic              w_psum_full;
  logic [PLW+ADDR_W-1:0] w_pix_rdata;

  // Fields of the held packet: {type, dst, src, payload}
  assign w_type    = r_hold[PWIDTH-1 -: 2];
  assign w_dst     = r_hold[PWIDTH-3 -: ADDR_W];
  assign w_src     = r_hold[PLW +: ADDR_W];
  assign w_payload = r_hold[PLW-1:0];

`ifdef DEPKT_BROADCAST_EN
  assign w_addr_ok = (w_dst == LP_MY_ADDR) || (w_dst == {ADDR_W{1'b1}});
`else
  assign w_addr_ok = (w_dst == LP_MY_ADDR);
`endif

  assign w_drop   = !w_addr_ok || (w_type == 2'b11);
  assign w_active = (r_state == S_DECODE) || (r_state == S_WAIT);
  assign w_push   = w_active && !w_drop && !w_tgt_full;

  // Fullness of the FIFO chosen by the held packet's type
  always_comb begin
    w_tgt_full = 1'b0;
    case (w_type)
      T_IFMAP: w_tgt_full = w_pix_full;
      T_FILT:  w_tgt_full = w_filt_full;
      T_PSUM:  w_tgt_full = w_psum_full;
      default: w_tgt_full = 1'b0;
    endcase
  end

  // Control FSM: accept in IDLE, then decide drop, push or stall on the next cycles
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_hold     <= '0;
      r_drop_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (i_in_valid && r_in_ready) begin
            r_hold     <= i_in_data;
            r_in_ready <= 1'b0;
            r_state    <= S_DECODE;
          end
        end
        S_DECODE, S_WAIT: begin
          if (r_state == S_DECODE && w_drop && r_drop_cnt != 8'hFF)
            r_drop_cnt <= r_drop_cnt + 8'd1;
          if (w_drop || !w_tgt_full) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
          end else begin
            r_state    <= S_WAIT;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready = r_in_ready;
  assign o_drop_cnt = r_drop_cnt;
  assign o_state    = r_state;

  pe_depkt_fifo #(.W(PLW + ADDR_W), .DEPTH(FIFO_DEPTH)) u_pix_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push && (w_type == T_IFMAP)),
    .i_wdata ({w_src, w_payload}),
    .o_full  (w_pix_full),
    .o_valid (o_pix_valid),
    .i_ready (i_pix_ready),
    .o_rdata (w_pix_rdata)
  );

  assign o_pix_src  = w_pix_rdata[PLW +: ADDR_W];
  assign o_pix_data = w_pix_rdata[PLW-1:0];

  pe_depkt_fifo #(.W(NFILT*DWIDTH), .DEPTH(FIFO_DEPTH)) u_filt_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push && (w_type == T_FILT)),
    .i_wdata (w_payload[NFILT*DWIDTH-1:0]),
    .o_full  (w_filt_full),
    .o_valid (o_filt_valid),
    .i_ready (i_filt_ready),
    .o_rdata (o_filt_data)
  );

  pe_depkt_fifo #(.W(PSUM_W), .DEPTH(FIFO_DEPTH)) u_psum_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push && (w_type == T_PSUM)),
    .i_wdata (w_payload[PSUM_W-1:0]),
    .o_full  (w_psum_full),
    .o_valid (o_psum_valid),
    .i_ready (i_psum_ready),
    .o_rdata (o_psum_data)
  );
endmodule

// File: tb/tb_pe_depacketizer_fifo.sv
// Bench for pe_depacketizer_fifo at default parameters. A queue-based model
// classifies every accepted packet from the packet format rules, and each FIFO
// pop is compared against that model.
module tb_pe_depacketizer_fifo;
  localparam int ST_IDLE = 0;
  localparam int ST_WAIT = 2;
`ifdef DEPKT_BROADCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        pix_valid, pix_ready;
  logic [39:0] pix_data;
  logic [2:0]  pix_src;
  logic        filt_valid, filt_ready;
  logic [23:0] filt_data;
  logic        psum_valid, psum_ready;
  logic [15:0] psum_data;
  logic [7:0]  drop_cnt;
  logic [1:0]  state;

  int n_checks = 0;
  int n_errors = 0;
  int exp_drops = 0;
  bit rand_rdy = 1'b0;
  logic [63:0] exp_pix_q[$];
  logic [63:0] exp_filt_q[$];
  logic [63:0] exp_psum_q[$];
  logic [63:0] mon_e;

  pe_depacketizer_fifo dut (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_pix_valid(pix_valid), .i_pix_ready(pix_ready), .o_pix_data(pix_data), .o_pix_src(pix_src),
    .o_filt_valid(filt_valid), .i_filt_ready(filt_ready), .o_filt_data(filt_data),
    .o_psum_valid(psum_valid), .i_psum_ready(psum_ready), .o_psum_data(psum_data),
    .o_drop_cnt(drop_cnt), .o_state(state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: classify an accepted packet
  task automatic model_accept(input logic [1:0] t, input logic [2:0] dst,
                              input logic [2:0] src, input logic [39:0] pl);
    bit to_me;
    to_me = (dst == 3'd0) || (BCAST && dst == 3'b111);
    if (!to_me || t == 2'b11) begin
      if (exp_drops < 255) exp_drops++;
    end else if (t == 2'b01) exp_pix_q.push_back({21'd0, src, pl});
    else if (t == 2'b00)     exp_filt_q.push_back({40'd0, pl[23:0]});
    else                     exp_psum_q.push_back({48'd0, pl[15:0]});
  endtask

  // Driver: present one packet and hold it until it is accepted
  task automatic send(input logic [1:0] t, input logic [2:0] dst,
                      input logic [2:0] src, input logic [39:0] pl);
    int cyc = 0;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = {t, dst, src, pl};
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(t, dst, src, pl);
        done = 1'b1;
      end else if (++cyc > 200) begin
        chk("accept_timeout", 64'd0, 64'd1);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while ((exp_pix_q.size() + exp_filt_q.size() + exp_psum_q.size()) != 0 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    chk("drain_model_empty", 64'(exp_pix_q.size() + exp_filt_q.size() + exp_psum_q.size()), 64'd0);
    chk("drain_valids", {61'd0, pix_valid, filt_valid, psum_valid}, 64'd0);
  endtask

  // Scoreboard: every pop must match the head of that channel's expected queue
  always @(negedge clk) begin
    if (!rst) begin
      if (pix_valid && pix_ready) begin
        if (exp_pix_q.size() == 0) chk("pix_unexpected", 64'd1, 64'd0);
        else begin mon_e = exp_pix_q.pop_front(); chk("pix_pop", {21'd0, pix_src, pix_data}, mon_e); end
      end
      if (filt_valid && filt_ready) begin
        if (exp_filt_q.size() == 0) chk("filt_unexpected", 64'd1, 64'd0);
        else begin mon_e = exp_filt_q.pop_front(); chk("filt_pop", {40'd0, filt_data}, mon_e); end
      end
      if (psum_valid && psum_ready) begin
        if (exp_psum_q.size() == 0) chk("psum_unexpected", 64'd1, 64'd0);
        else begin mon_e = exp_psum_q.pop_front(); chk("psum_pop", {48'd0, psum_data}, mon_e); end
      end
    end
  end

  // Random output backpressure
  always @(posedge clk) begin
    #1;
    if (rand_rdy) begin
      pix_ready  = ($urandom_range(0, 3) != 0);
      filt_ready = ($urandom_range(0, 3) != 0);
      psum_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    pix_ready = 1'b1; filt_ready = 1'b1; psum_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_valids", {61'd0, pix_valid, filt_valid, psum_valid}, 64'd0);
    chk("rst_drop_cnt", {56'd0, drop_cnt}, 64'd0);
    chk("rst_state", {62'd0, state}, 64'(ST_IDLE));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

    // Ifmap routing
    send(2'b01, 3'b000, 3'b010, 40'h0102030405);
    chk("pix_no_fallthru", {63'd0, pix_valid}, 64'd0);
    @(posedge clk); #1;
    chk("pix_valid", {63'd0, pix_valid}, 64'd1);
    chk("pix_data", {24'd0, pix_data}, 64'h0102030405);
    chk("pix_src", {61'd0, pix_src}, 64'd2);
    wait_drain();

    // Filter routing
    send(2'b00, 3'b000, 3'b001, 40'h0000070809);
    @(posedge clk); #1;
    chk("filt_valid", {63'd0, filt_valid}, 64'd1);
    chk("filt_data", {40'd0, filt_data}, 64'h070809);
    chk("filt_others_idle", {62'd0, pix_valid, psum_valid}, 64'd0);
    wait_drain();

    // Backpressure: five filter packets into a four-deep FIFO
    filt_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(2'b00, 3'b000, 3'b001, 40'(i));
    @(posedge clk); #1;
    chk("bp_state_wait", {62'd0, state}, 64'(ST_WAIT));
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_head", {40'd0, filt_data}, 64'd1);
    filt_ready = 1'b1;
    wait_drain();

    // Drops: wrong address, reserved type, then saturation
    send(2'b00, 3'b011, 3'b001, 40'h11);
    send(2'b11, 3'b000, 3'b001, 40'h22);
    repeat (2) @(posedge clk);
    #1;
    chk("drop_cnt_2", {56'd0, drop_cnt}, 64'(exp_drops));
    chk("drop_no_push", {61'd0, pix_valid, filt_valid, psum_valid}, 64'd0);
    for (int i = 0; i < 300; i++) send(2'(3 * (i % 2)), 3'($urandom_range(1, 6)), 3'd0, 40'(i));
    repeat (2) @(posedge clk);
    #1;
    chk("drop_cnt_sat", {56'd0, drop_cnt}, 64'(exp_drops));

    // Reset while stalled in WAIT with a full pixel FIFO
    pix_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(2'b01, 3'b000, 3'(i), 40'(i * 3 + 1));
    @(posedge clk); #1;
    chk("rmid_state_wait", {62'd0, state}, 64'(ST_WAIT));
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rmid_pix_valid", {63'd0, pix_valid}, 64'd0);
    chk("rmid_in_ready", {63'd0, in_ready}, 64'd0);
    exp_pix_q.delete(); exp_filt_q.delete(); exp_psum_q.delete();
    exp_drops = 0;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rmid_rel_ready0", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    chk("rmid_rel_ready1", {63'd0, in_ready}, 64'd1);
    chk("rmid_drop_cnt", {56'd0, drop_cnt}, 64'd0);
    pix_ready = 1'b1;

    // Broadcast psum
    send(2'b10, 3'b111, 3'b001, 40'h000000BEEF);
    repeat (2) @(posedge clk);
    #1;
    chk("bcast_drop_cnt", {56'd0, drop_cnt}, 64'(exp_drops));
    wait_drain();

    // Random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 250; i++) begin
      logic [2:0] dst;
      int r;
      r = $urandom_range(0, 3);
      dst = (r < 2) ? 3'd0 : (r == 2) ? 3'b111 : 3'($urandom_range(0, 7));
      send(2'($urandom_range(0, 3)), dst, 3'($urandom_range(0, 7)), {8'($urandom), 32'($urandom)});
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
    @(posedge clk);
    rand_rdy = 1'b0;
    #2;
    pix_ready = 1'b1; filt_ready = 1'b1; psum_ready = 1'b1;
    wait_drain();
    chk("rand_drop_cnt", {56'd0, drop_cnt}, 64'(exp_drops));
    chk("final_state", {62'd0, state}, 64'(ST_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
